// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers for the split/join lane blocks.
// Contents:
//   state_t            - split FSM state encoding (RUN / FLUSH)
//   MAX_LANES, PTR_W   - widest lane mask the helpers accept, and its index width
//   next_set_bit_wrap  - next set bit above a position, wrapping to the lowest set bit
package axis_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam int MAX_LANES = 32;
  localparam int PTR_W     = 5;

  // Returns the lowest set bit of mask strictly above cur. If there is none,
  // it wraps to the lowest set bit. Passing cur = all-ones therefore yields the
  // lowest set bit. With an empty mask, cur is returned unchanged.
  function automatic logic [PTR_W-1:0] next_set_bit_wrap(
    input logic [MAX_LANES-1:0] mask,
    input logic [PTR_W-1:0]     cur
  );
    logic [PTR_W-1:0] res;
    res = cur;
    // Descending scans: the last write wins, so each scan keeps the lowest match.
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (mask[i]) res = PTR_W'(i);
    end
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) res = PTR_W'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_split_distributor_if.sv
// Bundles the distributor's stream signals.
// Signals:
//   oen               - output enable mask
//   s_axis_*          - single input stream
//   m_axis_*          - M_COUNT packed output streams
// Modports:
//   slave  - the distributor's view
//   master - the environment's view (source of s_axis, sink of m_axis)
interface axis_split_distributor_if #(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 64
);
  logic [M_COUNT-1:0]            oen;
  logic                          s_axis_tvalid;
  logic [DATA_WIDTH-1:0]         s_axis_tdata;
  logic                          s_axis_tlast;
  logic                          s_axis_tready;
  logic [M_COUNT-1:0]            m_axis_tvalid;
  logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata;
  logic [M_COUNT-1:0]            m_axis_tlast;
  logic [M_COUNT-1:0]            m_axis_tready;

  modport slave (
    input  oen, s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

  modport master (
    output oen, s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );
endinterface

// File: rtl/axis_split_lane.sv
// One output lane of the split distributor. It has two stages:
//   H : holds a word whose tlast is not known yet.
//   O : drives the output stream.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   load_i       - an accepted input beat targets this lane
//   data_i       - the input beat's data
//   flush_i      - the frame has ended; H drains to O tagged with tlast
//   m_tready_i   - downstream ready
//   accept_ok_o  - lane can take a new beat this cycle
//   h_full_o     - H holds a word
//   m_tvalid_o, m_tdata_o, m_tlast_o - registered output stream
module axis_split_lane
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  flush_i,
  input  logic                  m_tready_i,
  output logic                  accept_ok_o,
  output logic                  h_full_o,
  output logic                  m_tvalid_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tlast_o
);

  logic                  h_valid_q, h_valid_d;
  logic [DATA_WIDTH-1:0] h_data_q,  h_data_d;
  logic                  o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_data_q,  o_data_d;
  logic                  o_last_q,  o_last_d;

  logic consume;
  logic o_free;
  logic move_run;
  logic move_flush;

  assign consume    = o_valid_q & m_tready_i;
  assign o_free     = ~o_valid_q | consume;
  // In RUN, a new beat for this lane proves the held word was not the last one.
  // accept_ok_o guarantees O is free whenever H is full here.
  assign move_run   = load_i & h_valid_q;
  // In FLUSH, the held word is the lane's final word of the frame.
  assign move_flush = flush_i & h_valid_q & o_free;

  assign accept_ok_o = ~h_valid_q | ~o_valid_q | m_tready_i;
  assign h_full_o    = h_valid_q;
  assign m_tvalid_o  = o_valid_q;
  assign m_tdata_o   = o_data_q;
  assign m_tlast_o   = o_last_q;

  // Next-state for the H and O stages.
  always_comb begin
    h_valid_d = h_valid_q;
    h_data_d  = h_data_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    if (move_run || move_flush) begin
      o_valid_d = 1'b1;
      o_data_d  = h_data_q;
      o_last_d  = move_flush;
    end else if (consume) begin
      o_valid_d = 1'b0;
    end else begin
      o_valid_d = o_valid_q;
    end
    if (load_i) begin
      h_valid_d = 1'b1;
      h_data_d  = data_i;
    end else if (move_flush) begin
      h_valid_d = 1'b0;
    end else begin
      h_valid_d = h_valid_q;
    end
  end

  // Stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_valid_q <= 1'b0;
      h_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
    end else begin
      h_valid_q <= h_valid_d;
      h_data_q  <= h_data_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
    end
  end

endmodule

// File: rtl/axis_split_distributor.sv
// Fans one AXI-Stream input out to M_COUNT outputs. Within a frame, beats go
// round-robin across the enabled outputs, and every lane that received data
// closes its sub-frame with its own tlast.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - slave modport: oen, s_axis_* input stream, m_axis_* packed output streams
module axis_split_distributor
  import axis_pkg::*;
#(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  axis_split_distributor_if.slave    bus
);

  localparam int IDX_W = $clog2(M_COUNT);

  state_t             state_q, state_d;
  logic               frame_active_q, frame_active_d;
  logic [M_COUNT-1:0] oen_q, oen_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [M_COUNT-1:0] en_mask;
  logic [PTR_W-1:0]   first_w;
  logic [PTR_W-1:0]   target_w;
  logic [PTR_W-1:0]   next_w;
  logic [IDX_W-1:0]   target_idx;
  logic [M_COUNT-1:0] accept_ok;
  logic [M_COUNT-1:0] h_full;
  logic               s_ready;
  logic               accept;

  logic [M_COUNT-1:0]            m_tvalid;
  logic [M_COUNT*DATA_WIDTH-1:0] m_tdata;
  logic [M_COUNT-1:0]            m_tlast;

  // Before a frame starts, the live mask decides. Its lowest lane takes the first beat.
  assign en_mask    = frame_active_q ? oen_q : bus.oen;
  assign first_w    = next_set_bit_wrap(MAX_LANES'(bus.oen), {PTR_W{1'b1}});
  assign target_w   = frame_active_q ? PTR_W'(ptr_q) : first_w;
  assign target_idx = target_w[IDX_W-1:0];
  assign next_w     = next_set_bit_wrap(MAX_LANES'(en_mask), target_w);

  assign s_ready = ~rst & (state_q == ST_RUN) & (|en_mask) & accept_ok[target_idx];
  assign accept  = bus.s_axis_tvalid & s_ready;

  assign bus.s_axis_tready = s_ready;
  assign bus.m_axis_tvalid = m_tvalid;
  assign bus.m_axis_tdata  = m_tdata;
  assign bus.m_axis_tlast  = m_tlast;

  for (genvar i = 0; i < M_COUNT; i++) begin : g_lane
    axis_split_lane #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .load_i      (accept && (target_idx == IDX_W'(i))),
      .data_i      (bus.s_axis_tdata),
      .flush_i     (state_q == ST_FLUSH),
      .m_tready_i  (bus.m_axis_tready[i]),
      .accept_ok_o (accept_ok[i]),
      .h_full_o    (h_full[i]),
      .m_tvalid_o  (m_tvalid[i]),
      .m_tdata_o   (m_tdata[i*DATA_WIDTH +: DATA_WIDTH]),
      .m_tlast_o   (m_tlast[i])
    );
  end

  // Frame FSM: latches the mask at frame start, steps the pointer, and drains on tlast.
  always_comb begin
    state_d        = state_q;
    frame_active_d = frame_active_q;
    oen_d          = oen_q;
    ptr_d          = ptr_q;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (!frame_active_q) begin
            oen_d          = bus.oen;
            frame_active_d = 1'b1;
          end else begin
            oen_d          = oen_q;
          end
          ptr_d = next_w[IDX_W-1:0];
          if (bus.s_axis_tlast) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (h_full == '0) begin
          state_d        = ST_RUN;
          frame_active_d = 1'b0;
          ptr_d          = '0;
        end else begin
          state_d        = ST_FLUSH;
        end
      end
      default: begin
        state_d        = ST_RUN;
        frame_active_d = 1'b0;
        ptr_d          = '0;
      end
    endcase
  end

  // FSM and frame registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      frame_active_q <= 1'b0;
      oen_q          <= '0;
      ptr_q          <= '0;
    end else begin
      state_q        <= state_d;
      frame_active_q <= frame_active_d;
      oen_q          <= oen_d;
      ptr_q          <= ptr_d;
    end
  end

endmodule

// File: tb/tb_axis_split_distributor.sv
// Scoreboarded testbench for axis_split_distributor.
// The driver computes the lane and the tlast tag of every beat it sends.
// Each expected result is pushed to that lane's queue. The monitor pops from
// the queue on every output handshake and compares.
module tb_axis_split_distributor;

  localparam int M  = 4;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  axis_split_distributor_if #(.M_COUNT(M), .DATA_WIDTH(DW)) bus_if ();

  axis_split_distributor #(.M_COUNT(M), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [DW:0] exp_q [M][$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Output monitor: on each handshake, compare {tlast,tdata} with the lane's queue head.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < M; i++) begin
        if (bus_if.m_axis_tvalid[i] && bus_if.m_axis_tready[i]) begin
          check_eq($sformatf("lane%0d_has_expected", i), 128'(exp_q[i].size() > 0), 128'(1));
          if (exp_q[i].size() > 0)
            check_eq($sformatf("lane%0d_beat", i),
                     128'({bus_if.m_axis_tlast[i], bus_if.m_axis_tdata[i*DW +: DW]}),
                     128'(exp_q[i].pop_front()));
        end
      end
    end
  end

  int stall_cycles;

  task automatic send_beat(input logic [DW-1:0] d, input logic last, input int lane, input logic exp_last);
    int cyc;
    bit ok;
    bus_if.s_axis_tvalid = 1'b1;
    bus_if.s_axis_tdata  = d;
    bus_if.s_axis_tlast  = last;
    ok  = 1'b0;
    cyc = 0;
    while (cyc < 300) begin
      @(negedge clk);
      if (bus_if.s_axis_tready) begin
        ok = 1'b1;
        break;
      end
      stall_cycles++;
      cyc++;
    end
    check_eq("accept_within_budget", 128'(ok), 128'(1));
    if (ok) exp_q[lane].push_back({exp_last, d});
    @(posedge clk);
    #1;
    bus_if.s_axis_tvalid = 1'b0;
    bus_if.s_axis_tlast  = 1'b0;
  endtask

  // Sends n beats. If chg_at >= 0, oen switches to new_oen right after beat chg_at.
  task automatic send_frame(input int n, input logic [DW-1:0] base, input int chg_at,
                            input logic [M-1:0] new_oen, input bit do_last);
    logic [M-1:0] m;
    int lanes[$];
    int cnt;
    m = bus_if.oen;
    for (int j = 0; j < M; j++) if (m[j]) lanes.push_back(j);
    cnt = lanes.size();
    for (int k = 0; k < n; k++) begin
      send_beat(base + DW'(k), do_last && (k == n - 1), lanes[k % cnt], do_last && (k + cnt >= n));
      if (k == chg_at) bus_if.oen = new_oen;
    end
  endtask

  task automatic wait_drain(input string tag);
    int cyc;
    bit empty;
    empty = 1'b0;
    cyc   = 0;
    while (cyc < 200 && !empty) begin
      @(negedge clk);
      empty = 1'b1;
      for (int i = 0; i < M; i++) if (exp_q[i].size() != 0) empty = 1'b0;
      cyc++;
    end
    check_eq(tag, 128'(empty), 128'(1));
  endtask

  task automatic wait_ready(input string tag);
    int cyc;
    bit ok;
    ok  = 1'b0;
    cyc = 0;
    while (cyc < 50 && !ok) begin
      @(negedge clk);
      ok = bus_if.s_axis_tready;
      cyc++;
    end
    check_eq(tag, 128'(ok), 128'(1));
  endtask

  initial begin
    int lo;
    int hi_cnt;
    bus_if.oen           = 4'b1111;
    bus_if.s_axis_tvalid = 1'b1;
    bus_if.s_axis_tdata  = '0;
    bus_if.s_axis_tlast  = 1'b0;
    bus_if.m_axis_tready = 4'b1111;
    stall_cycles         = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_s_tready", 128'(bus_if.s_axis_tready), 128'(0));
    check_eq("rst_m_tvalid", 128'(bus_if.m_axis_tvalid), 128'(0));
    check_eq("rst_m_tlast",  128'(bus_if.m_axis_tlast),  128'(0));
    check_eq("rst_m_tdata",  128'(bus_if.m_axis_tdata),  128'(0));
    bus_if.s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic round-robin, 8 beats over 4 lanes, and a short stall for FLUSH only.
    send_frame(8, 64'h1000, -1, 4'b0000, 1'b1);
    lo = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_if.s_axis_tready) break;
      lo++;
    end
    check_eq("flush_stall_1_to_2", 128'(lo >= 1 && lo <= 2), 128'(1));
    wait_drain("drain_basic");

    // Sparse mask.
    @(posedge clk); #1;
    bus_if.oen = 4'b0101;
    send_frame(5, 64'h2000, -1, 4'b0000, 1'b1);
    wait_drain("drain_sparse");

    // Backpressure on lane 1.
    @(posedge clk); #1;
    bus_if.oen = 4'b1111;
    bus_if.m_axis_tready[1] = 1'b0;
    fork
      begin
        repeat (20) @(posedge clk);
        #1;
        bus_if.m_axis_tready[1] = 1'b1;
      end
    join_none
    stall_cycles = 0;
    send_frame(12, 64'h3000, -1, 4'b0000, 1'b1);
    check_eq("backpressure_stalled", 128'(stall_cycles > 5), 128'(1));
    wait_drain("drain_backpressure");

    // The mask changes mid-frame. The current frame keeps 1111, the next frame uses 0011.
    @(posedge clk); #1;
    send_frame(8, 64'h4000, 2, 4'b0011, 1'b1);
    wait_drain("drain_mask_a");
    @(posedge clk); #1;
    send_frame(4, 64'h5000, -1, 4'b0000, 1'b1);
    wait_drain("drain_mask_b");

    // With an empty mask, the input never becomes ready.
    @(posedge clk); #1;
    bus_if.oen           = 4'b0000;
    bus_if.s_axis_tvalid = 1'b1;
    bus_if.s_axis_tdata  = 64'hdead;
    hi_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus_if.s_axis_tready) hi_cnt++;
    end
    check_eq("oen_zero_stall", 128'(hi_cnt), 128'(0));
    @(posedge clk); #1;
    bus_if.s_axis_tvalid = 1'b0;
    bus_if.oen           = 4'b1111;

    // Reset in the middle of a frame.
    send_frame(4, 64'h6000, -1, 4'b0000, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < M; i++) exp_q[i].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_m_tvalid", 128'(bus_if.m_axis_tvalid), 128'(0));
    @(posedge clk); #1;
    send_frame(4, 64'h7000, -1, 4'b0000, 1'b1);
    wait_drain("drain_after_rst");

    // Short frame: only lanes 0 and 1 receive data.
    @(posedge clk); #1;
    send_frame(2, 64'h8000, -1, 4'b0000, 1'b1);
    wait_drain("drain_short");
    wait_ready("short_back_to_run");

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/axis_split_distributor.md
Name: axis_split_distributor

Overview:
- Fans one AXI-Stream input out to M_COUNT AXI-Stream outputs.
- Within a frame, beats go round-robin across the enabled outputs.
- Each enabled output that receives data ends its sub-frame with its own tlast.
- Sits upstream of the per-core lanes; it is the transmit-side counterpart of the multi-input join/merge arbiter, so that block's "all enabled inputs saw tlast" condition closes cleanly.

Parameters:
- M_COUNT, 4, number of output streams (≥2).
- DATA_WIDTH, 64, tdata width per stream.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- oen  in  M_COUNT  output enable mask; latched at frame start.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tlast  in  1  input frame end.
- s_axis_tready  out  1  input accept.
- m_axis_tvalid  out  M_COUNT  per-output valid.
- m_axis_tdata  out  M_COUNT*DATA_WIDTH  packed, output i at [i*DATA_WIDTH +: DATA_WIDTH].
- m_axis_tlast  out  M_COUNT  per-output frame end.
- m_axis_tready  in  M_COUNT  per-output ready.

Behaviour:
- Reset: state RUN, frame_active=0, ptr=0, all holds and out regs empty; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0; s_axis_tready=0 while rst is high.
- Lane i has two stages:
  - hold register H: a word whose tlast is not yet known;
  - out register O: drives m_axis_*[i].
- A beat counts as accepted when s_axis_tvalid and s_axis_tready are both high.
- Frame start, on the first accepted beat while frame_active=0:
  - oen_q <= oen; frame_active <= 1.
  - This beat targets the lowest set bit of oen, taken combinationally from live oen.
  - Changes to oen while frame_active=1 are ignored.
- Target selection: target = ptr. After each accepted beat, ptr moves to the next set bit of oen_q above ptr, wrapping to the lowest set bit.
- RUN, s_axis_tready = 1 when both hold:
  - enabled mask (live oen if !frame_active, else oen_q) is nonzero;
  - target lane can accept: H empty, or O empty, or m_axis_tready[target] high.
- If the enabled mask is zero, the block stalls with s_axis_tready=0 indefinitely. There is no drop.
- Accepted beat with tlast=0: if H[target] is full, H moves to O with tlast=0 on the same edge. The new beat loads H[target].
- Accepted beat with tlast=1: same H→O move, new beat loads H[target], then state goes to FLUSH.
- FLUSH:
  - s_axis_tready=0.
  - Each lane with H full moves H to O with tlast=1 once O is empty or being consumed (tvalid&tready) that cycle.
  - When all H are empty: state RUN, frame_active=0, ptr=0.
- Out register: O holds its value until tvalid&tready. Load and consume can happen on the same edge, giving one beat per cycle per lane.
- Latency:
  - A beat reaches m_axis only when the next beat for the same lane is accepted, or in FLUSH.
  - Earliest m_axis_tvalid is 1 cycle after the H→O edge.
  - FLUSH lasts at least 1 cycle.
- Short frames: if a frame has fewer beats than popcount(oen_q), unserved lanes emit nothing for that frame. The sender guarantees frame length ≥ popcount(oen).
- Back-to-back frames: the input stalls during FLUSH. The next frame's first beat is accepted no earlier than the cycle after FLUSH exits.
- Reset mid-frame: all held and presented beats are discarded. There are no partial tlast outputs.

Decomposition:
- Shared package axis_pkg holds:
  - state encoding ST_RUN=1'b0, ST_FLUSH=1'b1;
  - a next-set-bit-with-wrap function used for ptr, shared with the round-robin arbiter.
- Sub-module axis_split_lane (one per output, via generate) contains the H/O registers, H→O move logic, tlast tagging and the accept_ok indication.
- The top level owns the FSM, frame_active, oen_q and ptr.

Test Plan:
- Basic round-robin: M_COUNT=4, oen=4'b1111, all m_tready=1, 8-beat frame D0..D7 (tlast on D7) -> lane0 D0,D4(last), lane1 D1,D5(last), lane2 D2,D6(last), lane3 D3,D7(last); s_tready low for exactly the FLUSH cycle(s).
- Sparse mask: oen=4'b0101, 5-beat frame D0..D4 -> lane0 D0,D2,D4(last); lane2 D1,D3(last); lanes 1 and 3 never assert tvalid.
- Backpressure: oen=4'b1111, m_tready[1]=0 for 20 cycles, 12-beat frame -> s_tready drops when lane1 is the target with H and O full; all beats arrive in order once released, with no loss or duplication.
- Mask handling:
  - oen changed 1111→0011 after beat 2 -> current frame keeps using 1111;
  - next frame uses 0011;
  - oen=0 -> s_tready stays 0 with s_tvalid=1.
- Reset mid-frame: rst pulsed after beat 3 of an 8-beat frame -> next cycle all m_tvalid=0; a following 4-beat frame distributes from lane0.
- Short frame: oen=4'b1111, 2-beat frame A,B -> lane0 A(last), lane1 B(last), lanes 2 and 3 silent, FSM back in RUN.
